// File: rtl/ddr2_bank_cmd_gen_if.sv
// Request handshake and DDR2 command-pad bundle for ddr2_bank_cmd_gen.
// The slave modport is the command generator; the master modport is the traffic source or bench.
interface ddr2_bank_cmd_gen_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_bank;
    logic [12:0] req_row;
    logic [9:0]  req_col;
    logic        cke_pad;
    logic        csbar_pad;
    logic        rasbar_pad;
    logic        casbar_pad;
    logic        webar_pad;
    logic [1:0]  ba_pad;
    logic [12:0] a_pad;
    logic        rw_issued;

    modport master (
        output req_valid, req_write, req_bank, req_row, req_col,
        input  req_ready, cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad,
               ba_pad, a_pad, rw_issued
    );

    modport slave (
        input  req_valid, req_write, req_bank, req_row, req_col,
        output req_ready, cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad,
               ba_pad, a_pad, rw_issued
    );
endinterface

// File: rtl/ddr2_bank_cmd_gen.sv
// Open-page DDR2 command issuer: one request at a time, per-bank row tracking, registered pads.
// Row hit -> RD/WR one cycle after accept; req_ready only in IDLE. DDR2_AUTO_PRE_EN adds auto-precharge.
module ddr2_bank_cmd_gen #(
    parameter int unsigned TRP_MIN  = 4,
    parameter int unsigned TRCD_MIN = 3,
    parameter int unsigned TRAS_MIN = 8
) (
    input  logic               clk,
    input  logic               reset,
    ddr2_bank_cmd_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_RAS, PRE, WAIT_RP, ACT, WAIT_RCD, RW} state_t;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_RD    = 4'b0101;
    localparam logic [3:0] CMD_WR    = 4'b0100;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    state_t      state_q, state_d;
    logic [1:0]  bank_q, bank_d;
    logic [12:0] row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic        write_q, write_d;

    logic [3:0]  open_q, open_d;
    logic [12:0] open_row_q [4];
    logic [12:0] open_row_d [4];
    logic [7:0]  since_pre_q [4];
    logic [7:0]  since_pre_d [4];
    logic [7:0]  since_act_q [4];
    logic [7:0]  since_act_d [4];

    logic        cke_q;
    logic [3:0]  cmd_q, cmd_d;
    logic [1:0]  ba_q, ba_d;
    logic [12:0] a_q, a_d;
    logic        rw_issued_q, rw_issued_d;
    logic        req_ready_q, req_ready_d;
    logic        accept;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic logic reached(input logic [7:0] c, input int unsigned lim);
        return 32'(c) >= lim;
    endfunction

    assign accept = bus.req_valid && req_ready_q;

    // Timing decisions use the counter values as they will be after this edge, so the
    // command registered one edge later lands exactly on the minimum distance.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        write_d     = write_q;
        open_d      = open_q;
        open_row_d  = open_row_q;
        cmd_d       = CMD_NOP;
        ba_d        = 2'b00;
        a_d         = 13'h0000;
        rw_issued_d = 1'b0;
        req_ready_d = 1'b0;
        for (int b = 0; b < 4; b++) begin
            since_pre_d[b] = sat_inc(since_pre_q[b]);
            since_act_d[b] = sat_inc(since_act_q[b]);
        end

        case (state_q)
            IDLE: begin
                req_ready_d = !accept;
                if (accept) begin
                    bank_d  = bus.req_bank;
                    row_d   = bus.req_row;
                    col_d   = bus.req_col;
                    write_d = bus.req_write;
                    if (open_q[bus.req_bank] && open_row_q[bus.req_bank] == bus.req_row) begin
                        state_d = RW;
                    end else if (open_q[bus.req_bank]) begin
                        state_d = reached(since_act_d[bus.req_bank], TRAS_MIN - 1) ? PRE : WAIT_RAS;
                    end else begin
                        state_d = reached(since_pre_d[bus.req_bank], TRP_MIN) ? ACT : WAIT_RP;
                    end
                end
            end
            WAIT_RAS: begin
                if (reached(since_act_d[bank_q], TRAS_MIN - 1)) state_d = PRE;
            end
            PRE: begin
                cmd_d               = CMD_PRE;
                ba_d                = bank_q;
                open_d[bank_q]      = 1'b0;
                since_pre_d[bank_q] = 8'h00;
                state_d = reached(since_pre_d[bank_q], TRP_MIN) ? ACT : WAIT_RP;
            end
            WAIT_RP: begin
                if (reached(since_pre_d[bank_q], TRP_MIN)) state_d = ACT;
            end
            ACT: begin
                cmd_d               = CMD_ACT;
                ba_d                = bank_q;
                a_d                 = row_q;
                open_d[bank_q]      = 1'b1;
                open_row_d[bank_q]  = row_q;
                since_act_d[bank_q] = 8'h00;
                state_d = reached(since_act_d[bank_q], TRCD_MIN - 1) ? RW : WAIT_RCD;
            end
            WAIT_RCD: begin
                if (reached(since_act_d[bank_q], TRCD_MIN - 1)) state_d = RW;
            end
            RW: begin
                cmd_d       = write_q ? CMD_WR : CMD_RD;
                ba_d        = bank_q;
                a_d         = {3'b000, col_q};
                rw_issued_d = 1'b1;
`ifdef DDR2_AUTO_PRE_EN
                a_d[10]             = 1'b1;
                open_d[bank_q]      = 1'b0;
                since_pre_d[bank_q] = 8'h00;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            bank_q      <= 2'b00;
            row_q       <= 13'h0000;
            col_q       <= 10'h000;
            write_q     <= 1'b0;
            open_q      <= 4'b0000;
            for (int b = 0; b < 4; b++) begin
                open_row_q[b]  <= 13'h0000;
                since_pre_q[b] <= 8'hFF;
                since_act_q[b] <= 8'hFF;
            end
            cke_q       <= 1'b0;
            cmd_q       <= CMD_DESEL;
            ba_q        <= 2'b00;
            a_q         <= 13'h0000;
            rw_issued_q <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            write_q     <= write_d;
            open_q      <= open_d;
            open_row_q  <= open_row_d;
            since_pre_q <= since_pre_d;
            since_act_q <= since_act_d;
            cke_q       <= 1'b1;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            a_q         <= a_d;
            rw_issued_q <= rw_issued_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.cke_pad    = cke_q;
    assign bus.csbar_pad  = cmd_q[3];
    assign bus.rasbar_pad = cmd_q[2];
    assign bus.casbar_pad = cmd_q[1];
    assign bus.webar_pad  = cmd_q[0];
    assign bus.ba_pad     = ba_q;
    assign bus.a_pad      = a_q;
    assign bus.rw_issued  = rw_issued_q;
endmodule

// File: tb/tb_ddr2_bank_cmd_gen.sv
// Bench for ddr2_bank_cmd_gen: directed scenarios then random requests, checked against
// a timeline model computing each command's cycle from the bank timing rules.
module tb_ddr2_bank_cmd_gen;
    localparam int TRP  = 4;
    localparam int TRCD = 3;
    localparam int TRAS = 8;
`ifdef DDR2_AUTO_PRE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   nop_bad = 0;

    ddr2_bank_cmd_gen_if bus();

    ddr2_bank_cmd_gen #(.TRP_MIN(TRP), .TRCD_MIN(TRCD), .TRAS_MIN(TRAS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic        rw;
    } rec_t;

    rec_t mon_q[$];
    rec_t exp_q[$];

    wire [3:0] pad_cmd = {bus.csbar_pad, bus.rasbar_pad, bus.casbar_pad, bus.webar_pad};

    // Record every non-NOP command with the edge number that launched it.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            if (pad_cmd[3])
                nop_bad++;
            else if (pad_cmd != C_NOP)
                mon_q.push_back('{cyc, pad_cmd, bus.ba_pad, bus.a_pad, bus.rw_issued});
            else if (bus.ba_pad != 2'b00 || bus.a_pad != 13'h0000 || bus.rw_issued)
                nop_bad++;
        end
    end

    // Model state: per-bank open row and the cycles of the last ACT and last precharge.
    bit          m_open [4];
    logic [12:0] m_row  [4];
    int          m_act  [4];
    int          m_pre  [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 1'b0;
            m_row[b]  = 13'h0000;
            m_act[b]  = -1000;
            m_pre[b]  = -1000;
        end
    endtask

    task automatic predict(input logic w, input logic [1:0] b, input logic [12:0] r,
                           input logic [9:0] c, input int e);
        int act_t, pre_t, rw_t;
        exp_q.delete();
        if (m_open[b] && m_row[b] == r) begin
            rw_t = e + 1;
        end else begin
            if (m_open[b]) begin
                pre_t = imax(e + 1, m_act[b] + TRAS);
                exp_q.push_back('{pre_t, C_PRE, b, 13'h0000, 1'b0});
                m_pre[b] = pre_t;
                act_t = pre_t + TRP + 1;
            end else begin
                act_t = imax(e + 1, m_pre[b] + TRP + 1);
            end
            exp_q.push_back('{act_t, C_ACT, b, r, 1'b0});
            m_act[b]  = act_t;
            m_open[b] = 1'b1;
            m_row[b]  = r;
            rw_t = act_t + TRCD;
        end
        exp_q.push_back('{rw_t, w ? C_WR : C_RD, b, {2'b00, AUTO, c}, 1'b1});
        if (AUTO) begin
            m_open[b] = 1'b0;
            m_pre[b]  = rw_t;
        end
    endtask

    task automatic compare_cmds(input string tag);
        chk({tag, "/ncmd"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            chk({tag, "/cycle"}, mon_q[i].t, exp_q[i].t);
            chk({tag, "/cmd"}, mon_q[i].cmd, exp_q[i].cmd);
            chk({tag, "/ba"}, mon_q[i].ba, exp_q[i].ba);
            if (exp_q[i].cmd == C_PRE)
                chk({tag, "/pre_a10"}, mon_q[i].a[10], 1'b0);
            else
                chk({tag, "/a"}, mon_q[i].a, exp_q[i].a);
            chk({tag, "/rw_issued"}, mon_q[i].rw, exp_q[i].rw);
        end
        mon_q.delete();
    endtask

    task automatic scramble();
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_bank  = 2'($urandom_range(0, 3));
        bus.req_row   = 13'($urandom);
        bus.req_col   = 10'($urandom);
    endtask

    // Presents one request at a negedge; returns the acceptance edge.
    task automatic present(input logic w, input logic [1:0] b, input logic [12:0] r,
                           input logic [9:0] c, input string tag, output int e);
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready"}, bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_bank  = b;
        bus.req_row   = r;
        bus.req_col   = c;
        e = cyc + 1;
        predict(w, b, r, c, e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble();
    endtask

    task automatic do_req(input logic w, input logic [1:0] b, input logic [12:0] r,
                          input logic [9:0] c, input string tag);
        int e, rw_t;
        present(w, b, r, c, tag, e);
        rw_t = exp_q[exp_q.size() - 1].t;
        while (cyc < rw_t) @(negedge clk);
        chk({tag, "/rw_pulse"}, bus.rw_issued, 1'b1);
        chk({tag, "/busy_at_rw"}, bus.req_ready, 1'b0);
        @(negedge clk);
        chk({tag, "/ready_after"}, bus.req_ready, 1'b1);
        chk({tag, "/rw_drop"}, bus.rw_issued, 1'b0);
        compare_cmds(tag);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst/cke", bus.cke_pad, 1'b0);
        chk("rst/cmd", pad_cmd, 4'b1111);
        chk("rst/ba", bus.ba_pad, 2'b00);
        chk("rst/a", bus.a_pad, 13'h0000);
        chk("rst/ready", bus.req_ready, 1'b0);
        chk("rst/rw_issued", bus.rw_issued, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel/cke", bus.cke_pad, 1'b1);
        chk("rel/cmd", pad_cmd, C_NOP);
        chk("rel/ready", bus.req_ready, 1'b1);
        model_reset();
    endtask

    initial begin
        int e, first_t;
        logic [1:0] rb;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_bank  = 2'b00;
        bus.req_row   = 13'h0000;
        bus.req_col   = 10'h000;
        model_reset();
        @(negedge clk);
        apply_reset(3);

        do_req(1'b1, 2'd1, 13'h123, 10'h010, "closed_wr");
        do_req(1'b0, 2'd1, 13'h123, 10'h020, "row_hit_rd");
        do_req(1'b0, 2'd1, 13'h456, 10'h030, "row_miss_rd");

        // Abort a request right after its first command; nothing further may appear.
        present(1'b0, 2'd1, 13'h789, 10'h044, "abort", e);
        first_t = exp_q[0].t;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        while (cyc < first_t) @(negedge clk);
        apply_reset(2);
        repeat (12) @(negedge clk);
        compare_cmds("abort");

        do_req(1'b0, 2'd1, 13'h456, 10'h050, "post_reset_rd");
        do_req(1'b1, 2'd2, 13'h010, 10'h100, "wr_pair_a");
        do_req(1'b1, 2'd2, 13'h010, 10'h104, "wr_pair_b");

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                scramble();
                @(negedge clk);
            end
            rb = 2'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), rb,
                   ($urandom_range(0, 1) != 0) ? (13'h0AA + 13'(rb)) : 13'($urandom),
                   10'($urandom), "random");
        end

        chk("nop_fields_clean", nop_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ddr2_bank_cmd_gen.md
Name: ddr2_bank_cmd_gen

Overview:
Bank-aware DDR2 command issuer. It accepts single read/write requests (bank, row, column) over a valid/ready handshake and drives the command pads with correctly ordered and spaced ACT, PRE, RD and WR commands. The policy is open-page, with per-bank open-row tracking. It sits between the test traffic source and the DDR2 pad model, and is the producer of the command stream that the bank/row checker monitors.

Parameters:
TRP_MIN, 4, minimum NOP cycles between PRE and the next ACT to the same bank (PRE→ACT distance = TRP_MIN+1 cycles)
TRCD_MIN, 3, ACT→RD/WR distance in cycles (minimum 1)
TRAS_MIN, 8, minimum ACT→PRE distance in cycles, same bank

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1=WR, 0=RD
req_bank  in  2  target bank
req_row  in  13  target row
req_col  in  10  target column
cke_pad  out  1  clock enable
csbar_pad  out  1  chip select, active-low
rasbar_pad  out  1  RAS#
casbar_pad  out  1  CAS#
webar_pad  out  1  WE#
ba_pad  out  2  bank address
a_pad  out  13  address
rw_issued  out  1  one-cycle pulse in the cycle RD/WR is on the pads

Behaviour:
- All pad outputs are registered. Command encodings as {cs,ras,cas,we}:
  - NOP = 0111
  - ACT = 0011
  - PRE = 0010
  - RD = 0101
  - WR = 0100
- NOP cycles drive ba_pad=0 and a_pad=0.
- Reset (reset==0 at an edge):
  - cke_pad=0, csbar/ras/cas/webar=1, ba_pad=0, a_pad=0, req_ready=0, rw_issued=0.
  - All banks marked closed; per-bank since_pre and since_act counters set to 0xFF (saturated, timing satisfied); FSM to IDLE.
  - Reset mid-operation aborts the in-flight request with no further commands.
- First cycle after reset release: cke_pad=1, NOP, req_ready=1.
- Per-bank counters: 8-bit saturating at 0xFF, incremented every cycle.
  - since_pre cleared on PRE to that bank.
  - since_act cleared on ACT to that bank.
- Handshake:
  - req_ready=1 only in IDLE. A transfer occurs when req_valid && req_ready at an edge; fields are latched.
  - req_ready drops the following cycle and rises again the cycle after RD/WR is issued.
- FSM states: IDLE, WAIT_RAS, PRE, WAIT_RP, ACT, WAIT_RCD, RW.
- From IDLE on acceptance:
  - Row hit (bank open, row equal) → RW; RD/WR on pads the cycle after acceptance.
  - Bank closed → ACT (waits in WAIT_RP until since_pre ≥ TRP_MIN).
  - Row miss → WAIT_RAS until since_act ≥ TRAS_MIN-1, then PRE.
- PRE:
  - Drives ba=bank, a_pad[10]=0 (single bank); marks bank closed → WAIT_RP.
  - WAIT_RP exits to ACT once TRP_MIN NOP cycles have elapsed. ACT is therefore exactly TRP_MIN+1 cycles after PRE.
- ACT:
  - Drives ba=bank, a_pad=row; marks bank open with open_row=row.
  - Goes to WAIT_RCD for TRCD_MIN-1 NOPs, then RW. RD/WR is exactly TRCD_MIN cycles after ACT.
- RW:
  - Drives RD or WR, ba=bank, a_pad[9:0]=col, a_pad[12:11]=0, a_pad[10] per the optional feature.
  - rw_issued=1 → IDLE.
- All commands other than the latched bank's are NOP. Only one request is in flight, and there is no reordering.
- Request fields changing while req_ready=0 have no effect.

Optional Feature:
DDR2_AUTO_PRE_EN:
- Defined: RD/WR is issued with a_pad[10]=1 (auto-precharge). In that cycle the bank is marked closed and its since_pre is cleared. The next access to that bank takes the closed path and honours TRP_MIN from the RD/WR cycle. Row hits never occur across requests.
- Undefined: a_pad[10]=0 on RD/WR; open-page behaviour as above.

Test Plan:
1. Hold reset=0 for 3 cycles, release → during reset cke_pad=0, csbar_pad=1, req_ready=0; first cycle after release cke_pad=1, NOP, req_ready=1.
2. Closed bank: WR bank1 row 0x123 col 0x010 accepted at cycle E (defaults) → ACT ba=1 a=0x123 at E+1, WR ba=1 a=0x010 at E+4 with rw_issued=1, req_ready=1 at E+5.
3. Row hit after test 2: RD bank1 row 0x123 col 0x020 → RD at acceptance+1, no ACT/PRE.
4. Row miss directly after test 3: RD bank1 row 0x456 → PRE ba=1 a[10]=0 no earlier than 8 cycles after the test-2 ACT; ACT a=0x456 exactly 5 cycles after PRE; RD 3 cycles after ACT. A bank checker with TRP_MIN=4 stays silent.
5. Assert reset during WAIT_RP of test 4, release → pads NOP, cke 0→1; next RD bank1 row 0x456 → ACT then RD (closed path, no PRE).
6. With DDR2_AUTO_PRE_EN: two WRs to bank2 row 0x010 back-to-back → first WR a[10]=1; second ACT a=0x010 exactly 5 cycles after first WR, then WR 3 cycles later.
